// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl
//   Sequencer for the decryption direction of the serial-in/serial-out AES-128
//   datapath. It captures NB ciphertext bits, runs the inverse cipher
//   (ARK with key NR, then NR-1 rounds of ISR/ISB/ARK/IMC, then ISR/ISB),
//   and has the output register load the final ARK with key 0 before it
//   shifts the plaintext out serially.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   EN                    global advance enable (also gates datapath enables)
//   start                 decrypt request, honoured only in IDLE
//   WR_EN_IN_REG          input SIPO shift enable
//   WR_EN_STATE_REG       state register write enable
//   WR_EN_OUT_REG         output PISO parallel-load strobe
//   Sel_State[2:0]        state mux select (0 block, 4 ARK, 5 ISB, 6 ISR, 7 IMC)
//   Sel_Key[3:0]          round-key select, always the round counter
//   din_ready             sender must present one ciphertext bit per EN cycle
//   dout_valid            DOUT carries a plaintext bit this EN cycle
//   busy                  high in every state except IDLE
//   done                  pulse on the last serial-out cycle
module aes_inv_cipher_ctrl #(
  parameter int NB = 128,
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       EN,
  input  logic       start,
  output logic       WR_EN_IN_REG,
  output logic       WR_EN_STATE_REG,
  output logic       WR_EN_OUT_REG,
  output logic [2:0] Sel_State,
  output logic [3:0] Sel_Key,
  output logic       din_ready,
  output logic       dout_valid,
  output logic       busy,
  output logic       done
);

  localparam int BC_W = $clog2(NB);

  localparam logic [2:0] SEL_BLOCK = 3'd0;
  localparam logic [2:0] SEL_ARK   = 3'd4;
  localparam logic [2:0] SEL_ISB   = 3'd5;
  localparam logic [2:0] SEL_ISR   = 3'd6;
  localparam logic [2:0] SEL_IMC   = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_IN,
    LATCH,
    ARK0,
    RND,
    FIN_ISR,
    FIN_ISB,
    OUT_LD,
    SHIFT
  } state_t;

  state_t            state, state_n;
  logic [BC_W-1:0]   bc, bc_n;
  logic [3:0]        rc, rc_n;
  logic [1:0]        ph, ph_n;

  // Everything advances only on EN edges, so EN=0 freezes state and
  // therefore every (Moore-decoded) output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bc    <= '0;
      rc    <= '0;
      ph    <= '0;
    end else if (EN) begin
      state <= state_n;
      bc    <= bc_n;
      rc    <= rc_n;
      ph    <= ph_n;
    end
  end

  // Outputs depend only on registered state/counters; start only steers
  // the next state.
  always_comb begin
    state_n         = state;
    bc_n            = bc;
    rc_n            = rc;
    ph_n            = ph;
    WR_EN_IN_REG    = 1'b0;
    WR_EN_STATE_REG = 1'b0;
    WR_EN_OUT_REG   = 1'b0;
    Sel_State       = SEL_BLOCK;
    Sel_Key         = rc;
    din_ready       = 1'b0;
    dout_valid      = 1'b0;
    done            = 1'b0;
    busy            = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_IN;
          bc_n    = '0;
          rc_n    = 4'(NR);
        end
      end
      LOAD_IN: begin
        WR_EN_IN_REG = 1'b1;
        din_ready    = 1'b1;
        bc_n         = bc + BC_W'(1);
        if (bc == BC_W'(NB - 1)) state_n = LATCH;
      end
      LATCH: begin
        WR_EN_STATE_REG = 1'b1;
        state_n         = ARK0;
      end
      ARK0: begin
        // rc still holds NR here, so the initial ARK uses the last round key.
        Sel_State       = SEL_ARK;
        WR_EN_STATE_REG = 1'b1;
        rc_n            = 4'(NR - 1);
        ph_n            = 2'd0;
        state_n         = RND;
      end
      RND: begin
        WR_EN_STATE_REG = 1'b1;
        ph_n            = ph + 2'd1;
        case (ph)
          2'd0:    Sel_State = SEL_ISR;
          2'd1:    Sel_State = SEL_ISB;
          2'd2:    Sel_State = SEL_ARK;
          default: begin
            Sel_State = SEL_IMC;
            if (rc == 4'd1) state_n = FIN_ISR;
            else            rc_n    = rc - 4'd1;
          end
        endcase
      end
      FIN_ISR: begin
        Sel_State       = SEL_ISR;
        WR_EN_STATE_REG = 1'b1;
        rc_n            = 4'd0;
        state_n         = FIN_ISB;
      end
      FIN_ISB: begin
        Sel_State       = SEL_ISB;
        WR_EN_STATE_REG = 1'b1;
        state_n         = OUT_LD;
      end
      OUT_LD: begin
        // The PISO captures ARK(state, key 0) directly: the final round key
        // add never goes back through the state register.
        WR_EN_OUT_REG = 1'b1;
        bc_n          = '0;
        state_n       = SHIFT;
      end
      SHIFT: begin
        dout_valid = 1'b1;
        bc_n       = bc + BC_W'(1);
        if (bc == BC_W'(NB - 1)) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
